// File: rtl/smbs_pkg.sv
// Shared types and constants for the serial-message bus switch frame decoder.
// Holds the FSM state enum and the fixed header field widths.
package smbs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PORT    = 3'd1,
        LINE    = 3'd2,
        LEN     = 3'd3,
        PAYLOAD = 3'd4,
        DONE    = 3'd5
    } smbs_state_t;

    localparam int   PORT_W    = 2;
    localparam int   LINE_W    = 2;
    localparam int   NUM_PORTS = 4;
    localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/smbs_shift_cnt.sv
// Generic MSB-first header field shifter with its own bit counter.
// Ports: clk, rst (async high), en (consume a bit), bit_in,
//        value (assembled field), last (en on the field's final bit).
module smbs_shift_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] value,
    output logic         last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] cnt;

    assign last = en && (cnt == CW'(W - 1));

    // The counter self-clears on the final bit, so it is always zero
    // when the owning state is next entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            cnt   <= '0;
        end else if (en) begin
            value <= (value << 1) | W'(bit_in);
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/smbs_ctrl.sv
// Serial frame decoder in front of the bus switch: parses start/port/line/len
// and steers exactly len payload bits to the switch with stable selects.
// Ports: clk, rst (async high), serIn, serValid in; serOut, P_select,
//        L_select, outValid, done, busy out.
module smbs_ctrl
    import smbs_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serIn,
    input  logic                 serValid,
    output logic                 serOut,
    output logic [NUM_PORTS-1:0] P_select,
    output logic [LINE_W-1:0]    L_select,
    output logic                 outValid,
    output logic                 done,
    output logic                 busy
);

    smbs_state_t state, state_next;

    logic [PORT_W-1:0] port_q;
    logic [LINE_W-1:0] line_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_nxt;
    logic [LEN_W-1:0]  pay_cnt;
    logic              port_last, line_last, len_last;
    logic              port_en, line_en, len_en;
    logic              pay_take;

    assign port_en  = (state == PORT) && serValid;
    assign line_en  = (state == LINE) && serValid;
    assign len_en   = (state == LEN) && serValid;
    assign pay_take = (state == PAYLOAD) && serValid;

    // Length value including the bit being consumed this cycle.
    assign len_nxt  = (len_q << 1) | LEN_W'(serIn);

    smbs_shift_cnt #(.W(PORT_W)) u_port (
        .clk    (clk),
        .rst    (rst),
        .en     (port_en),
        .bit_in (serIn),
        .value  (port_q),
        .last   (port_last)
    );

    smbs_shift_cnt #(.W(LINE_W)) u_line (
        .clk    (clk),
        .rst    (rst),
        .en     (line_en),
        .bit_in (serIn),
        .value  (line_q),
        .last   (line_last)
    );

    smbs_shift_cnt #(.W(LEN_W)) u_len (
        .clk    (clk),
        .rst    (rst),
        .en     (len_en),
        .bit_in (serIn),
        .value  (len_q),
        .last   (len_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pay_cnt <= '0;
        end else if (len_last) begin
            pay_cnt <= len_nxt;
        end else if (pay_take) begin
            pay_cnt <= pay_cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (serValid && (serIn == START_BIT)) begin
                    state_next = PORT;
                end
            end
            PORT: begin
                if (port_last) begin
                    state_next = LINE;
                end
            end
            LINE: begin
                if (line_last) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                if (len_last) begin
                    state_next = (len_nxt != '0) ? PAYLOAD : DONE;
                end
            end
            PAYLOAD: begin
                if (pay_take && (pay_cnt == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Selects decode only the registered state and fields, so they are
    // glitch-free; serOut/outValid are a deliberate same-cycle path.
    always_comb begin
        serOut   = 1'b0;
        outValid = 1'b0;
        P_select = '0;
        L_select = '0;
        done     = (state == DONE);
        busy     = (state != IDLE);
        if (state == PAYLOAD) begin
            P_select[port_q] = 1'b1;
            L_select         = line_q;
            outValid         = serValid;
            serOut           = serValid && serIn;
        end
    end

endmodule

// File: tb/tb_smbs_ctrl.sv
// Self-checking bench for smbs_ctrl: directed and random frames checked
// cycle by cycle against a bit-stream model of the frame format.
module tb_smbs_ctrl;

    localparam int LEN_W = 4;
    localparam int HDR   = 1 + 2 + 2 + LEN_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       serIn;
    logic       serValid;
    logic       serOut;
    logic [3:0] P_select;
    logic [1:0] L_select;
    logic       outValid;
    logic       done;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int stall_plan[0:63];

    smbs_ctrl #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .serIn    (serIn),
        .serValid (serValid),
        .serOut   (serOut),
        .P_select (P_select),
        .L_select (L_select),
        .outValid (outValid),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Drives one frame (optional idle zeros first) and checks every cycle.
    // pay[k] is the k-th payload bit on the wire.
    task automatic run_frame(input logic [1:0] p, input logic [1:0] l,
                             input int len, input logic [14:0] pay,
                             input int spct, input bit done_one,
                             input int noise);
        bit         q[$];
        int         idx;
        int         delivered;
        int         guard;
        bit         v;
        bit         in_pay;
        logic [9:0] exp_v;
        logic [9:0] act_v;
        logic [3:0] ps;
        logic [3:0] lv;
        ps = 4'b0001 << p;
        lv = 4'(len);
        q.push_back(1'b1);
        q.push_back(p[1]);
        q.push_back(p[0]);
        q.push_back(l[1]);
        q.push_back(l[0]);
        for (int i = LEN_W - 1; i >= 0; i--) q.push_back(lv[i]);
        for (int i = 0; i < len; i++) q.push_back(pay[i]);
        for (int i = 0; i < noise; i++) begin
            @(negedge clk);
            serValid = 1'b1;
            serIn    = 1'b0;
            #1;
            n_chk++;
            if ({busy, done, outValid, P_select} !== 7'b0) begin
                n_fail++;
                $display("FAIL idle_noise: got %b expected 0000000",
                         {busy, done, outValid, P_select});
            end
        end
        idx       = 0;
        delivered = 0;
        guard     = 0;
        while (idx < q.size() && guard < 1000) begin
            guard++;
            @(negedge clk);
            if (stall_plan[idx] > 0) begin
                v = 1'b0;
                stall_plan[idx]--;
            end else begin
                v = ($urandom_range(99) >= spct);
            end
            serValid = v;
            serIn    = v ? q[idx] : 1'($urandom_range(1));
            #1;
            in_pay   = (idx >= HDR);
            exp_v    = {in_pay && v && q[idx], in_pay && v,
                        in_pay ? ps : 4'b0, in_pay ? l : 2'b0,
                        1'b0, idx > 0};
            act_v    = {serOut, outValid, P_select, L_select, done, busy};
            n_chk++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL frame_cycle idx=%0d v=%0d: got %b expected %b",
                         idx, v, act_v, exp_v);
            end
            if (v) begin
                if (outValid === 1'b1) delivered++;
                idx++;
            end
        end
        n_chk++;
        if (guard >= 1000) begin
            n_fail++;
            $display("FAIL frame_timeout: got idx %0d expected %0d",
                     idx, q.size());
        end
        @(negedge clk);
        serValid = done_one ? 1'b1 : 1'($urandom_range(1));
        serIn    = done_one ? 1'b1 : 1'($urandom_range(1));
        #1;
        act_v = {serOut, outValid, P_select, L_select, done, busy};
        n_chk++;
        if (act_v !== 10'b0000000011) begin
            n_fail++;
            $display("FAIL done_cycle: got %b expected 0000000011", act_v);
        end
        n_chk++;
        if (delivered != len) begin
            n_fail++;
            $display("FAIL payload_count: got %0d expected %0d",
                     delivered, len);
        end
        for (int i = 0; i < 64; i++) stall_plan[i] = 0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        serValid = 1'b0;
        serIn    = 1'b0;
        for (int i = 0; i < 64; i++) stall_plan[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({serOut, outValid, P_select, L_select, done, busy} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 0000000000",
                     {serOut, outValid, P_select, L_select, done, busy});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_frame(2'b10, 2'b01, 3, 15'b101, 0, 1'b0, 0);
    endtask

    task automatic test_stalls();
        stall_plan[3]        = 2;
        stall_plan[HDR + 1]  = 1;
        run_frame(2'b10, 2'b01, 3, 15'b101, 0, 1'b0, 0);
    endtask

    task automatic test_zero_len();
        run_frame(2'b11, 2'b00, 0, 15'b0, 0, 1'b0, 0);
    endtask

    task automatic test_idle_noise();
        run_frame(2'b00, 2'b11, 1, 15'b1, 0, 1'b0, 3);
    endtask

    task automatic test_mid_reset();
        bit q[$];
        q = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0};
        for (int i = 0; i <= HDR + 1; i++) begin
            @(negedge clk);
            serValid = 1'b1;
            serIn    = q[i];
        end
        #1;
        n_chk++;
        if ({outValid, P_select, L_select} !== 7'b1_0010_10) begin
            n_fail++;
            $display("FAIL pre_reset_payload: got %b expected 1001010",
                     {outValid, P_select, L_select});
        end
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({serOut, outValid, P_select, L_select, done, busy} !== 10'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0000000000",
                     {serOut, outValid, P_select, L_select, done, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serValid = 1'b1;
            serIn    = 1'b0;
            #1;
            n_chk++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset_quiet: got %b expected 00",
                         {done, busy});
            end
            @(negedge clk);
        end
        run_frame(2'b01, 2'b10, 5, 15'b10110, 0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame(2'b01, 2'b11, 2, 15'b11, 0, 1'b1, 0);
        run_frame(2'b11, 2'b01, 4, 15'b0110, 0, 1'b1, 0);
        run_frame(2'b00, 2'b00, 0, 15'b0, 0, 1'b1, 0);
        run_frame(2'b10, 2'b10, 1, 15'b0, 0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_frame(2'($urandom_range(3)), 2'($urandom_range(3)),
                      $urandom_range(15), 15'($urandom),
                      30, 1'($urandom_range(1)), $urandom_range(2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_zero_len();
        test_idle_noise();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
